// File: rtl/rice_bus_arbiter.sv
// Round-robin bus arbiter: N request channels share one master port.
// Responses are steered back to channels in acceptance order.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_enable                permits new (unlocked) grants
//   i_request_valid/o_request_ready, i_address/i_write/i_write_data/i_strobe
//                           per-channel request handshake and payload
//   o_response_valid/i_response_ready, o_read_data, o_error
//                           per-channel response handshake, shared data
//   o_m_request_*/i_m_request_ready   master request port
//   i_m_response_*/o_m_response_ready master response port
//   o_outstanding           accepted requests awaiting response
//   o_protocol_error        sticky: response arrived with nothing pending
module rice_bus_arbiter #(
  parameter int CHANNELS        = 2,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int SW = DATA_WIDTH / 8,
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_enable,
  input  logic [CHANNELS-1:0]                     i_request_valid,
  output logic [CHANNELS-1:0]                     o_request_ready,
  input  logic [CHANNELS-1:0][ADDRESS_WIDTH-1:0]  i_address,
  input  logic [CHANNELS-1:0]                     i_write,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]     i_write_data,
  input  logic [CHANNELS-1:0][SW-1:0]             i_strobe,
  output logic [CHANNELS-1:0]                     o_response_valid,
  input  logic [CHANNELS-1:0]                     i_response_ready,
  output logic [DATA_WIDTH-1:0]                   o_read_data,
  output logic                                    o_error,
  output logic                                    o_m_request_valid,
  input  logic                                    i_m_request_ready,
  output logic [ADDRESS_WIDTH-1:0]                o_m_address,
  output logic                                    o_m_write,
  output logic [DATA_WIDTH-1:0]                   o_m_write_data,
  output logic [SW-1:0]                           o_m_strobe,
  input  logic                                    i_m_response_valid,
  output logic                                    o_m_response_ready,
  input  logic [DATA_WIDTH-1:0]                   i_m_read_data,
  input  logic                                    i_m_error,
  output logic [OW-1:0]                           o_outstanding,
  output logic                                    o_protocol_error
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic          perr_q, perr_d;

  logic [IW-1:0] rr_idx;
  logic          rr_hit;
  logic [IW-1:0] gnt;
  logic [IW-1:0] head;
  logic          full, empty;
  logic          req_hs, rsp_hs;
  int            j;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == OW'(MAX_OUTSTANDING));
  assign head  = fifo_q[rd_q];

  // Descending scan so the smallest offset from the pointer wins.
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    j      = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (i_request_valid[IW'(j)]) begin
        rr_hit = 1'b1;
        rr_idx = IW'(j);
      end
    end
  end

  assign gnt = lock_q ? lock_idx_q : rr_idx;

  always_comb begin
    o_m_request_valid = 1'b0;
    if (i_rst_n) begin
      if (lock_q) o_m_request_valid = i_request_valid[gnt];
      else        o_m_request_valid = rr_hit && i_enable && !full;
    end
  end

  assign req_hs = o_m_request_valid && i_m_request_ready;

  always_comb begin
    o_request_ready = '0;
    if (o_m_request_valid) o_request_ready[gnt] = i_m_request_ready;
  end

  assign o_m_address    = i_address[gnt];
  assign o_m_write      = i_write[gnt];
  assign o_m_write_data = i_write_data[gnt];
  assign o_m_strobe     = i_strobe[gnt];

  // With nothing pending, stray responses are drained, not stalled.
  assign o_m_response_ready = empty ? 1'b1 : i_response_ready[head];
  assign rsp_hs = i_m_response_valid && o_m_response_ready && !empty;

  always_comb begin
    o_response_valid = '0;
    if (i_rst_n && !empty) o_response_valid[head] = i_m_response_valid;
  end

  assign o_read_data      = i_m_read_data;
  assign o_error          = i_m_error;
  assign o_outstanding    = cnt_q;
  assign o_protocol_error = perr_q;

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    perr_d     = perr_q | (i_m_response_valid && empty);
    if (req_hs) begin
      lock_d = 1'b0;
      ptr_d  = (gnt == IW'(CHANNELS - 1)) ? '0 : gnt + 1'b1;
      wr_d   = wrap_inc(wr_q);
    end else if (o_m_request_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt;
    end
    if (rsp_hs) rd_d = wrap_inc(rd_q);
    unique case (1'b1)
      (req_hs && !rsp_hs): cnt_d = cnt_q + 1'b1;
      (rsp_hs && !req_hs): cnt_d = cnt_q - 1'b1;
      default:             cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      perr_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      perr_q     <= perr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (req_hs) fifo_q[wr_q] <= gnt;
  end

endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Scoreboard bench for rice_bus_arbiter (4 channels, 2 outstanding).
// Directed scenarios followed by randomized traffic.
module tb_rice_bus_arbiter;
  localparam int C  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 2;
  localparam int OW = $clog2(MO + 1);

  typedef struct {
    int           ch;
    logic [DW-1:0] data;
    logic         err;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic                   en;
  logic [C-1:0]           rv;
  logic [C-1:0]           rrdy_o;
  logic [C-1:0][AW-1:0]   addr;
  logic [C-1:0]           wr;
  logic [C-1:0][DW-1:0]   wd;
  logic [C-1:0][SW-1:0]   st;
  logic [C-1:0]           o_response_valid;
  logic [C-1:0]           rrdy;
  logic [DW-1:0]          o_read_data;
  logic                   o_error;
  logic                   o_m_request_valid;
  logic                   mrdy;
  logic [AW-1:0]          o_m_address;
  logic                   o_m_write;
  logic [DW-1:0]          o_m_write_data;
  logic [SW-1:0]          o_m_strobe;
  logic                   mrv;
  logic                   o_m_response_ready;
  logic [DW-1:0]          mrd;
  logic                   merr;
  logic [OW-1:0]          o_outstanding;
  logic                   o_protocol_error;

  rice_bus_arbiter #(
    .CHANNELS(C), .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_request_valid(rv), .o_request_ready(rrdy_o),
    .i_address(addr), .i_write(wr),
    .i_write_data(wd), .i_strobe(st),
    .o_response_valid(o_response_valid),
    .i_response_ready(rrdy),
    .o_read_data(o_read_data), .o_error(o_error),
    .o_m_request_valid(o_m_request_valid),
    .i_m_request_ready(mrdy),
    .o_m_address(o_m_address), .o_m_write(o_m_write),
    .o_m_write_data(o_m_write_data),
    .o_m_strobe(o_m_strobe),
    .i_m_response_valid(mrv),
    .o_m_response_ready(o_m_response_ready),
    .i_m_read_data(mrd), .i_m_error(merr),
    .o_outstanding(o_outstanding),
    .o_protocol_error(o_protocol_error)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: pointer, lock, and the ordered list of accepted
  // requests still waiting for a response.
  int   m_ptr;
  bit   m_lock;
  int   m_lch;
  bit   m_perr;
  ent_t slave_q[$];
  ent_t exp_q[$];
  int   dut_log[$];
  int   acc_ch;
  logic snap_mv;
  logic snap_mrr;
  logic snap_perr;
  logic [OW-1:0] snap_out;

  task automatic set_req(input int c);
    rv[c]   = 1'b1;
    addr[c] = $urandom;
    wr[c]   = 1'($urandom % 2);
    wd[c]   = $urandom;
    st[c]   = SW'($urandom % 16);
  endtask

  task automatic slave_drive(input bit go);
    if (go && slave_q.size() > 0) begin
      mrv  = 1'b1;
      mrd  = slave_q[0].data;
      merr = slave_q[0].err;
    end else begin
      mrv  = 1'b0;
      mrd  = $urandom;
      merr = 1'($urandom % 2);
    end
  endtask

  // Called at posedge+1 with inputs applied; checks at posedge+4,
  // advances the model, returns at the next posedge+1.
  task automatic step();
    int   g;
    bit   ev;
    ent_t e;
    #3;
    acc_ch    = -1;
    snap_mv   = o_m_request_valid;
    snap_mrr  = o_m_response_ready;
    snap_perr = o_protocol_error;
    snap_out  = o_outstanding;
    if (!rst_n) begin
      m_ptr  = 0;
      m_lock = 0;
      m_perr = 0;
      slave_q.delete();
      exp_q.delete();
    end else begin
      g  = -1;
      ev = 0;
      if (m_lock) begin
        g  = m_lch;
        ev = rv[g];
      end else begin
        for (int k = 0; k < C; k++)
          if (g < 0 && rv[(m_ptr + k) % C]) g = (m_ptr + k) % C;
        ev = (g >= 0) && en && (slave_q.size() < MO);
      end
      chk("m_valid", 64'(o_m_request_valid), 64'(ev));
      chk("req_ready", 64'(rrdy_o),
          (ev && mrdy) ? (64'(1) << g) : 64'(0));
      if (ev) begin
        chk("m_addr", 64'(o_m_address), 64'(addr[g]));
        chk("m_write", 64'(o_m_write), 64'(wr[g]));
        chk("m_wdata", 64'(o_m_write_data), 64'(wd[g]));
        chk("m_strobe", 64'(o_m_strobe), 64'(st[g]));
      end
      chk("outstanding", 64'(o_outstanding), 64'(slave_q.size()));
      chk("m_rsp_ready", 64'(o_m_response_ready),
          slave_q.size() == 0 ? 64'(1) : 64'(rrdy[slave_q[0].ch]));
      chk("perr", 64'(o_protocol_error), 64'(m_perr));
      if (o_m_request_valid && mrdy)
        for (int c = 0; c < C; c++)
          if (rrdy_o[c]) dut_log.push_back(c);
      if (mrv && slave_q.size() == 0) m_perr = 1;
      if (mrv && slave_q.size() > 0 && rrdy[slave_q[0].ch])
        void'(slave_q.pop_front());
      if (ev && mrdy) begin
        e.ch   = g;
        e.data = $urandom;
        e.err  = ($urandom % 4) == 0;
        slave_q.push_back(e);
        exp_q.push_back(e);
        m_ptr  = (g + 1) % C;
        m_lock = 0;
        acc_ch = g;
      end else if (ev) begin
        m_lock = 1;
        m_lch  = g;
      end
    end
    @(posedge clk);
    #1;
    if (acc_ch >= 0) rv[acc_ch] = 1'b0;
  endtask

  // Response monitor: checks routing against the acceptance-order queue.
  always @(negedge clk) begin : mon
    ent_t e;
    if (rst_n === 1'b1) begin
      if (mrv && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("rsp_route", 64'(o_response_valid), 64'(1) << e.ch);
        chk("rsp_data", 64'(o_read_data), 64'(e.data));
        chk("rsp_err", 64'(o_error), 64'(e.err));
        if (rrdy[e.ch]) void'(exp_q.pop_front());
      end else begin
        chk("rsp_none", 64'(o_response_valid), 64'(0));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    rv    = '0;
    mrv   = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    rv   = '0;
    en   = 1'b1;
    rrdy = '1;
    repeat (6) begin
      slave_drive(1);
      step();
    end
    mrv = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int idx, input int exp);
    chk(nm, 64'(dut_log.size() > idx ? dut_log[idx] : -1), 64'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    rv    = '0;
    addr  = '0;
    wr    = '0;
    wd    = '0;
    st    = '0;
    rrdy  = '1;
    mrdy  = 1'b1;
    mrv   = 1'b0;
    mrd   = '0;
    merr  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_out", 64'(o_outstanding), 64'(0));
    chk("rst_perr", 64'(o_protocol_error), 64'(0));
    chk("rst_mrr", 64'(o_m_response_ready), 64'(1));
    chk("rst_mv", 64'(o_m_request_valid), 64'(0));

    // Two channels requesting back to back alternate.
    dut_log.delete();
    repeat (8) begin
      if (!rv[0]) set_req(0);
      if (!rv[1]) set_req(1);
      slave_drive(1);
      step();
    end
    for (int k = 0; k < 4; k++) chk_log("rr_alt", k, k % 2);
    drain();

    // Lock holds through enable drop and a competing request.
    do_reset();
    dut_log.delete();
    mrdy = 1'b0;
    set_req(1);
    step();
    set_req(0);
    en = 1'b0;
    step();
    step();
    mrdy = 1'b1;
    step();
    en = 1'b1;
    step();
    chk_log("lock_first", 0, 1);
    chk_log("lock_next", 1, 0);
    drain();

    // Full FIFO blocks grants, no bypass on a same-cycle pop.
    do_reset();
    dut_log.delete();
    set_req(0);
    set_req(1);
    step();
    step();
    set_req(2);
    step();
    chk("full_cnt", 64'(snap_out), 64'(2));
    chk("full_block", 64'(snap_mv), 64'(0));
    slave_drive(1);
    step();
    chk("pop_no_bypass", 64'(snap_mv), 64'(0));
    slave_drive(0);
    step();
    chk("grant_after_pop", 64'(snap_mv), 64'(1));
    chk_log("full_order", 2, 2);
    drain();

    // Pointer wrap with four channels.
    do_reset();
    dut_log.delete();
    set_req(1);
    step();
    set_req(3);
    set_req(1);
    slave_drive(1);
    step();
    slave_drive(1);
    step();
    chk_log("wrap0", 0, 1);
    chk_log("wrap1", 1, 3);
    chk_log("wrap2", 2, 1);
    drain();

    // Stray response: drained, not routed, sticky error.
    do_reset();
    rrdy = '0;
    mrv  = 1'b1;
    mrd  = $urandom;
    step();
    chk("stray_mrr", 64'(snap_mrr), 64'(1));
    mrv = 1'b0;
    repeat (3) step();
    chk("perr_sticky", 64'(snap_perr), 64'(1));
    rrdy = '1;
    do_reset();
    step();
    chk("perr_cleared", 64'(snap_perr), 64'(0));

    // Reset with one outstanding and a held lock.
    do_reset();
    dut_log.delete();
    set_req(0);
    step();
    mrdy = 1'b0;
    set_req(1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_out", 64'(o_outstanding), 64'(0));
    set_req(0);
    mrdy = 1'b1;
    step();
    chk_log("rst_ptr0", 1, 0);
    drain();

    // Randomized traffic with a reset in the middle.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 300) do_reset();
      for (int c = 0; c < C; c++)
        if (!rv[c] && ($urandom % 3) == 0) set_req(c);
      en   = ($urandom % 8) != 0;
      mrdy = ($urandom % 4) != 0;
      rrdy = C'($urandom);
      slave_drive(($urandom % 3) != 0);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rice_bus_arbiter.md
RICE_BUS_ARBITER -- requirements
Module: rice_bus_arbiter

Interface
REQ-001 Parameter CHANNELS, default 2: number of requesting bus channels (2..8).
REQ-002 Parameter ADDRESS_WIDTH, default 32: request address width.
REQ-003 Parameter DATA_WIDTH, default 32: write/read data width; strobe width is DATA_WIDTH/8.
REQ-004 Parameter MAX_OUTSTANDING, default 2: depth of the response-routing FIFO (1..8).
REQ-005 i_clk  input  1  single clock; all state on rising edge.
REQ-006 i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 i_enable  input  1  permits new grants when high.
REQ-008 i_request_valid  input  CHANNELS  per-channel request valid.
REQ-009 o_request_ready  output  CHANNELS  per-channel request accept.
REQ-010 i_address / i_write / i_write_data / i_strobe  input  CHANNELS x (ADDRESS_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8)  per-channel request payload.
REQ-011 o_response_valid  output  CHANNELS; i_response_ready  input  CHANNELS; o_read_data  output  DATA_WIDTH (shared); o_error  output  1 (shared).
REQ-012 o_m_request_valid  output  1; i_m_request_ready  input  1; o_m_address / o_m_write / o_m_write_data / o_m_strobe  output  payload of the granted channel.
REQ-013 i_m_response_valid  input  1; o_m_response_ready  output  1; i_m_read_data  input  DATA_WIDTH; i_m_error  input  1.
REQ-014 o_outstanding  output  clog2(MAX_OUTSTANDING+1)  count of accepted requests awaiting response.
REQ-015 o_protocol_error  output  1  sticky: response received with no outstanding request.

Function
REQ-016 Arbitration SHALL be round-robin: when unlocked, grant the lowest channel index >= pointer (wrapping) with i_request_valid high.
REQ-017 Grant when unlocked SHALL be combinational (zero added request latency); master payload SHALL mux from the granted channel.
REQ-018 o_m_request_valid SHALL equal the granted channel's valid, gated by (unlocked: i_enable && FIFO not full; locked: 1).
REQ-019 o_request_ready[g] SHALL equal i_m_request_ready while o_m_request_valid is high; all other ready bits 0.
REQ-020 When o_m_request_valid is high and i_m_request_ready low, the arbiter SHALL lock the grant to that channel until the handshake; lock ignores i_enable deassertion and higher-priority arrivals.
REQ-021 On request handshake: clear lock, pointer <= (granted+1) mod CHANNELS, push granted index into FIFO.
REQ-022 FIFO full SHALL block new grants even if a pop occurs the same cycle (no bypass); a locked request is never present while full.
REQ-023 Response routing: head = FIFO head index; o_response_valid[head] = i_m_response_valid && FIFO not empty; others 0; o_read_data/o_error pass through i_m_read_data/i_m_error.
REQ-024 o_m_response_ready SHALL be i_response_ready[head] when FIFO not empty, else 1 (drain stray response).
REQ-025 On response handshake, pop FIFO; responses SHALL return to channels in request-acceptance order.
REQ-026 Simultaneous push and pop SHALL leave o_outstanding unchanged and keep ordering.
REQ-027 i_m_response_valid high with FIFO empty SHALL set o_protocol_error (sticky until reset); no o_response_valid asserted.
REQ-028 i_enable low SHALL NOT stall responses.

Reset
REQ-029 On i_clk edge with i_rst_n low: pointer 0, lock clear, FIFO empty, o_outstanding 0, o_protocol_error 0; all valid/ready outputs 0 except o_m_response_ready follows REQ-024 (1 when empty).
REQ-030 Reset mid-transaction SHALL discard outstanding entries; the bench SHALL not expect routing of responses issued before reset.

Verification
REQ-031 Ch0 and ch1 request continuously, m_ready=1, m_response immediate -> grants alternate 0,1,0,1; responses routed in same order.
REQ-032 Ch1 valid, m_ready low 3 cycles, ch0 raises valid and i_enable drops during wait -> master stays on ch1 with stable payload; ch1 accepted cycle 4; ch0 granted next with i_enable high.
REQ-033 MAX_OUTSTANDING=2, two accepted, no responses -> o_outstanding=2, o_m_request_valid 0; one response with pending request same cycle -> request still blocked that cycle, granted next.
REQ-034 CHANNELS=4, requests from ch3 then ch1 with pointer=2 -> ch3 granted first, then ch1 (wrap).
REQ-035 i_m_response_valid=1 with FIFO empty -> o_m_response_ready=1, no o_response_valid, o_protocol_error=1 held until i_rst_n low.
REQ-036 Reset asserted with o_outstanding=1 and lock held -> next cycle all outputs at reset values, pointer 0.
